// File: rtl/apb_master_pkg.sv
// Shared types and helpers for the APB master engine: FSM states, queued
// command/response records and the byte-strobe width helper.
package apb_master_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

    localparam int APB_STRB_W = strb_w(APB_DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
    } cmd_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } rsp_t;

endpackage

// File: rtl/apb_master_if.sv
// Command, response and APB bus signals of the master engine; the master
// modport is the engine side, the slave modport is the sequencer/peripheral side.
interface apb_master_if
    import apb_master_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;
    logic [DATA_W/8-1:0]   cmd_strb;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic                  busy;

    logic                  PSELx;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_W-1:0]     PADDR;
    logic [DATA_W-1:0]     PWDATA;
    logic [DATA_W/8-1:0]   PSTRB;
    logic [DATA_W-1:0]     PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
               PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
               PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
               PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
               PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

endinterface

// File: rtl/apb_sync_fifo.sv
// Single-clock FIFO with occupancy count; push and pop may share an edge,
// which also lets a full FIFO accept a push while it is being popped.
module apb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    // Storage is cleared on reset so the read port presents zero afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem[wrPtr] <= din;
                wrPtr      <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rdPtr];
    assign full  = (count == ($clog2(DEPTH) + 1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/apb_master_engine.sv
// APB master: queued commands become APB transfers with wait states, slave
// errors, timeout abort and back-to-back launch; results return in order.
module apb_master_engine
    import apb_master_pkg::*;
#(
    parameter int ADDR_W    = APB_ADDR_W,
    parameter int DATA_W    = APB_DATA_W,
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic         PCLK,
    input  logic         PRESET,
    apb_master_if.master bus
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_t state, stateNext;
    logic [CNT_W-1:0] waitCnt, waitNext;

    logic                pwriteQ;
    logic [ADDR_W-1:0]   paddrQ;
    logic [DATA_W-1:0]   pwdataQ;
    logic [DATA_W/8-1:0] pstrbQ;

    cmd_t cmdIn, cmdOut;
    rsp_t rspIn, rspOut;
    logic cmdFull, cmdEmpty, cmdPop;
    logic rspFull, rspEmpty, rspPush, rspPop;
    logic [$clog2(CMD_DEPTH):0] cmdCount;
    logic [$clog2(RSP_DEPTH):0] rspCount;
    logic fin, rspRoom, launch;

    assign cmdIn.write = bus.cmd_write;
    assign cmdIn.addr  = bus.cmd_addr;
    assign cmdIn.wdata = bus.cmd_wdata;
    assign cmdIn.strb  = bus.cmd_write ? bus.cmd_strb : '0;

    apb_sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) cmdFifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (bus.cmd_valid && bus.cmd_ready),
        .din   (cmdIn),
        .pop   (cmdPop),
        .dout  (cmdOut),
        .full  (cmdFull),
        .empty (cmdEmpty),
        .count (cmdCount)
    );

    apb_sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) rspFifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (rspPush),
        .din   (rspIn),
        .pop   (rspPop),
        .dout  (rspOut),
        .full  (rspFull),
        .empty (rspEmpty),
        .count (rspCount)
    );

    assign rspPop = bus.rsp_valid && bus.rsp_ready;
    assign fin    = (state == ACCESS) && bus.PREADY;

    // A new transfer only starts if its response will have a slot, counting
    // the response being written on this same edge.
    assign rspRoom = fin ? ((int'(rspCount) - int'(rspPop)) < (RSP_DEPTH - 1))
                         : (!rspFull || rspPop);
    assign launch  = !cmdEmpty && rspRoom;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= IDLE;
            waitCnt <= '0;
            pwriteQ <= 1'b0;
            paddrQ  <= '0;
            pwdataQ <= '0;
            pstrbQ  <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitNext;
            if (cmdPop) begin
                pwriteQ <= cmdOut.write;
                paddrQ  <= cmdOut.addr;
                pwdataQ <= cmdOut.wdata;
                pstrbQ  <= cmdOut.strb;
            end
        end
    end

    always_comb begin
        stateNext = state;
        waitNext  = '0;
        cmdPop    = 1'b0;
        rspPush   = 1'b0;
        rspIn     = '0;
        case (state)
            IDLE: begin
                if (launch) begin
                    cmdPop    = 1'b1;
                    stateNext = SETUP;
                end
            end
            SETUP: begin
                stateNext = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    rspPush     = 1'b1;
                    rspIn.rdata = pwriteQ ? '0 : bus.PRDATA;
                    rspIn.err   = bus.PSLVERR;
                    if (launch) begin
                        cmdPop    = 1'b1;
                        stateNext = SETUP;
                    end else begin
                        stateNext = IDLE;
                    end
                end else if ((TIMEOUT != 0) && (waitCnt == WAIT_LAST)) begin
                    rspPush       = 1'b1;
                    rspIn.err     = 1'b1;
                    rspIn.timeout = 1'b1;
                    stateNext     = IDLE;
                end else begin
                    waitNext = waitCnt + CNT_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.cmd_ready   = !cmdFull && !PRESET;
    assign bus.rsp_valid   = !rspEmpty;
    assign bus.rsp_rdata   = rspOut.rdata;
    assign bus.rsp_err     = rspOut.err;
    assign bus.rsp_timeout = rspOut.timeout;
    assign bus.busy        = (state != IDLE) || (cmdCount != '0);

    assign bus.PSELx   = (state != IDLE);
    assign bus.PENABLE = (state == ACCESS);
    assign bus.PWRITE  = pwriteQ;
    assign bus.PADDR   = paddrQ;
    assign bus.PWDATA  = pwdataQ;
    assign bus.PSTRB   = pstrbQ;

endmodule

// File: tb/tb_apb_master_engine.sv
// Self-checking bench for apb_master_engine: table of single transfers against
// a responding slave model, plus latency, back-to-back, stall and reset sequences.
module tb_apb_master_engine;

    localparam logic [31:0] KEY = 32'hDEADBEE7;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        timeout;
    } exp_t;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waitCycles;
        bit          slvErr;
        bit          stuck;
        logic [31:0] expRdata;
        bit          expErr;
        bit          expTimeout;
        logic [3:0]  expStrb;
        int          expAccess;
    } vec_t;

    logic pclk = 1'b0;
    logic preset = 1'b0;
    always #5 pclk = ~pclk;

    apb_master_if bus ();

    apb_master_engine #(
        .CMD_DEPTH (4),
        .RSP_DEPTH (4),
        .TIMEOUT   (16)
    ) dut (
        .PCLK   (pclk),
        .PRESET (preset),
        .bus    (bus)
    );

    int checkCount = 0;
    int passCount  = 0;
    exp_t expQ[$];
    exp_t sbEntry;

    int slaveWait = 0;
    bit slaveErr = 1'b0;
    bit slaveStuck = 1'b0;
    int waitCtr = 0;

    logic [31:0] capAddr, capWdata;
    logic        capWrite;
    logic [3:0]  capStrb;
    int capAccess = 0;
    int setupCount = 0;
    int pselCycles = 0;
    int pselFalls = 0;
    logic prevSel = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // Slave model and bus monitor, evaluated between active edges.
    always @(negedge pclk) begin
        if (bus.PSELx && bus.PENABLE) begin
            bus.PREADY = !slaveStuck && (waitCtr >= slaveWait);
            waitCtr++;
            capAccess++;
        end else begin
            bus.PREADY = 1'b0;
            waitCtr = 0;
        end
        bus.PSLVERR = slaveErr && bus.PREADY;
        bus.PRDATA  = bus.PADDR ^ KEY;
        if (bus.PSELx && !bus.PENABLE) begin
            capAddr  = bus.PADDR;
            capWrite = bus.PWRITE;
            capWdata = bus.PWDATA;
            capStrb  = bus.PSTRB;
            capAccess = 0;
            setupCount++;
        end
        if (bus.PSELx) pselCycles++;
        if (prevSel && !bus.PSELx) pselFalls++;
        prevSel = bus.PSELx;
    end

    // Scoreboard: each accepted response is compared with the oldest expectation.
    always @(negedge pclk) begin
        if (!preset && bus.rsp_valid && bus.rsp_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("rspUnexpected", 32'd1, 32'd0);
            end else begin
                sbEntry = expQ.pop_front();
                checkOutput("rspRdata", bus.rsp_rdata, sbEntry.rdata);
                checkOutput("rspErr", {31'b0, bus.rsp_err}, {31'b0, sbEntry.err});
                checkOutput("rspTimeout", {31'b0, bus.rsp_timeout}, {31'b0, sbEntry.timeout});
            end
        end
    end

    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input exp_t e);
        logic rdy;
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_strb  = s;
        expQ.push_back(e);
        do begin
            @(negedge pclk);
            rdy = bus.cmd_ready;
            @(posedge pclk);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) checkOutput("cmdAcceptTimeout", 32'd0, 32'd1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drainWait(input string name);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(posedge pclk);
            n++;
        end
        @(posedge pclk);
        #1;
        checkOutput(name, expQ.size(), 32'd0);
    endtask

    task automatic waitFor(input string name, ref logic sig);
        int n;
        n = 0;
        while (sig !== 1'b1 && n < 60) begin
            @(posedge pclk);
            #1;
            n++;
        end
        checkOutput(name, {31'b0, sig}, 32'd1);
    endtask

    vec_t vecs[8];
    int   stallBase;

    initial begin
        vecs[0] = '{1'b1, 32'h4,  32'hA5,       4'h1, 0,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'h1, 1};
        vecs[1] = '{1'b0, 32'h8,  32'h0,        4'hF, 3,  1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 4};
        vecs[2] = '{1'b0, 32'h10, 32'h0,        4'h0, 1,  1'b1, 1'b0, 32'hDEADBEF7, 1'b1, 1'b0, 4'h0, 2};
        vecs[3] = '{1'b1, 32'h20, 32'h12345678, 4'hC, 2,  1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 4'hC, 3};
        vecs[4] = '{1'b0, 32'h40, 32'h0,        4'h0, 15, 1'b0, 1'b0, 32'hDEADBEA7, 1'b0, 1'b0, 4'h0, 16};
        vecs[5] = '{1'b0, 32'h30, 32'h0,        4'h0, 0,  1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 4'h0, 16};
        vecs[6] = '{1'b0, 32'h34, 32'h0,        4'h0, 0,  1'b0, 1'b0, 32'hDEADBED3, 1'b0, 1'b0, 4'h0, 1};
        vecs[7] = '{1'b1, 32'h3C, 32'hFFFF0000, 4'h3, 0,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'h3, 1};

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.rsp_ready = 1'b0;

        #1 preset = 1'b1;
        #2;
        checkOutput("rst.PSELx", {31'b0, bus.PSELx}, 32'd0);
        checkOutput("rst.PENABLE", {31'b0, bus.PENABLE}, 32'd0);
        checkOutput("rst.rspValid", {31'b0, bus.rsp_valid}, 32'd0);
        checkOutput("rst.busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("rst.cmdReady", {31'b0, bus.cmd_ready}, 32'd0);
        checkOutput("rst.rspRdata", bus.rsp_rdata, 32'd0);
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        @(posedge pclk);
        #1;
        checkOutput("postRst.cmdReady", {31'b0, bus.cmd_ready}, 32'd1);

        // Latency from command push into an empty engine.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h50;
        bus.cmd_wdata = 32'h11;
        bus.cmd_strb  = 4'hF;
        expQ.push_back('{32'h0, 1'b0, 1'b0});
        @(negedge pclk);
        checkOutput("lat.cmdReady", {31'b0, bus.cmd_ready}, 32'd1);
        @(posedge pclk);
        #1 bus.cmd_valid = 1'b0;
        checkOutput("latN.PSELx", {31'b0, bus.PSELx}, 32'd0);
        @(posedge pclk); #1;
        checkOutput("latN1.PSELx", {31'b0, bus.PSELx}, 32'd1);
        checkOutput("latN1.PENABLE", {31'b0, bus.PENABLE}, 32'd0);
        @(posedge pclk); #1;
        checkOutput("latN2.PENABLE", {31'b0, bus.PENABLE}, 32'd1);
        checkOutput("latN2.rspValid", {31'b0, bus.rsp_valid}, 32'd0);
        @(posedge pclk); #1;
        checkOutput("latN3.rspValid", {31'b0, bus.rsp_valid}, 32'd1);
        checkOutput("latN3.PSELx", {31'b0, bus.PSELx}, 32'd0);
        bus.rsp_ready = 1'b1;
        drainWait("lat.drain");

        for (int i = 0; i < 8; i++) begin
            slaveWait  = vecs[i].waitCycles;
            slaveErr   = vecs[i].slvErr;
            slaveStuck = vecs[i].stuck;
            applyStimulus(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                          '{vecs[i].expRdata, vecs[i].expErr, vecs[i].expTimeout});
            drainWait($sformatf("v%0d.drain", i));
            checkOutput($sformatf("v%0d.PADDR", i), capAddr, vecs[i].addr);
            checkOutput($sformatf("v%0d.PWRITE", i), {31'b0, capWrite}, {31'b0, vecs[i].write});
            checkOutput($sformatf("v%0d.PSTRB", i), {28'b0, capStrb}, {28'b0, vecs[i].expStrb});
            if (vecs[i].write) checkOutput($sformatf("v%0d.PWDATA", i), capWdata, vecs[i].wdata);
            checkOutput($sformatf("v%0d.access", i), capAccess, vecs[i].expAccess);
        end
        slaveWait = 0;
        slaveErr = 1'b0;
        slaveStuck = 1'b0;

        // Four queued transfers run back-to-back with PSELx held high.
        pselCycles = 0;
        pselFalls = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h80 + 32'(i * 4), 32'h0, 4'h0, '{(32'h80 + 32'(i * 4)) ^ KEY, 1'b0, 1'b0});
        end
        drainWait("b2b.drain");
        checkOutput("b2b.pselCycles", pselCycles, 32'd8);
        checkOutput("b2b.pselFalls", pselFalls, 32'd1);

        // Response back-pressure: only RSP_DEPTH transfers may run.
        bus.rsp_ready = 1'b0;
        stallBase = setupCount;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'h0, '{(32'h100 + 32'(i * 4)) ^ KEY, 1'b0, 1'b0});
        end
        repeat (20) @(posedge pclk);
        #1;
        checkOutput("stall.transfers", setupCount - stallBase, 32'd4);
        checkOutput("stall.PSELx", {31'b0, bus.PSELx}, 32'd0);
        checkOutput("stall.busy", {31'b0, bus.busy}, 32'd1);
        checkOutput("stall.cmdReady", {31'b0, bus.cmd_ready}, 32'd1);
        for (int i = 6; i < 8; i++) begin
            applyStimulus(1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'h0, '{(32'h100 + 32'(i * 4)) ^ KEY, 1'b0, 1'b0});
        end
        checkOutput("stallFull.cmdReady", {31'b0, bus.cmd_ready}, 32'd0);
        bus.rsp_ready = 1'b1;
        drainWait("stall.drain");
        checkOutput("stall.totalTransfers", setupCount - stallBase, 32'd8);

        // Reset in the middle of an ACCESS phase.
        bus.rsp_ready = 1'b0;
        applyStimulus(1'b0, 32'h200, 32'h0, 4'h0, '{32'h200 ^ KEY, 1'b0, 1'b0});
        waitFor("rstSeq.rspValid", bus.rsp_valid);
        slaveStuck = 1'b1;
        applyStimulus(1'b0, 32'h204, 32'h0, 4'h0, '{32'h0, 1'b1, 1'b1});
        applyStimulus(1'b0, 32'h208, 32'h0, 4'h0, '{32'h208 ^ KEY, 1'b0, 1'b0});
        waitFor("rstSeq.inAccess", bus.PENABLE);
        #2 preset = 1'b1;
        #1;
        checkOutput("midRst.PSELx", {31'b0, bus.PSELx}, 32'd0);
        checkOutput("midRst.PENABLE", {31'b0, bus.PENABLE}, 32'd0);
        checkOutput("midRst.rspValid", {31'b0, bus.rsp_valid}, 32'd0);
        checkOutput("midRst.busy", {31'b0, bus.busy}, 32'd0);
        expQ.delete();
        slaveStuck = 1'b0;
        stallBase = setupCount;
        @(posedge pclk);
        #1 preset = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        checkOutput("afterRst.busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("afterRst.rspValid", {31'b0, bus.rsp_valid}, 32'd0);
        checkOutput("afterRst.cmdReady", {31'b0, bus.cmd_ready}, 32'd1);
        checkOutput("afterRst.noTransfer", setupCount - stallBase, 32'd0);
        bus.rsp_ready = 1'b1;
        applyStimulus(1'b0, 32'h20C, 32'h0, 4'h0, '{32'h20C ^ KEY, 1'b0, 1'b0});
        drainWait("afterRst.drain");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
